conv_relu_pool: RTL and testbench

Downstream stage of the conv PE. Consumes the PE's raster-ordered 2*WIDTH convolution results and applies ReLU, then 2x2 max-pooling with stride 2. Emits one pooled value per 2x2 window as a valid-qualified stream to the next layer's input buffer. There is no backpressure, because the conv PE cannot stall.

---
 rtl/conv_relu_pool.sv | 130 +++++++++++++
 tb/tb_conv_relu_pool.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// conv_relu_pool
//   Sits after the conv PE. Each raster-ordered 2*WIDTH-bit signed conv
//   result is optionally rectified and then 2x2 max-pooled with stride 2.
//   One pooled value is emitted per window as a valid-qualified stream.
//   There is no backpressure because the upstream PE cannot stall.
//
//   Build option: define RELU_EN to rectify pixels (negative -> 0) before
//   pooling. When it is undefined the block is a plain signed max-pool.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     clear      synchronous frame abort (counters, partial max, outputs)
//     in_valid   data_in carries a conv result this cycle
//     data_in    signed conv result, 2*WIDTH bits
//     out_valid  one-cycle pulse per pooled value
//     data_out   pooled value, held until the next pooled output
//     frame_done one-cycle pulse alongside the last pooled value of a frame
module conv_relu_pool #(
    parameter int WIDTH   = 9,
    parameter int ROW_LEN = 10,
    parameter int COL_LEN = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   data_in,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   data_out,
    output logic                 frame_done
);

    localparam int DW       = 2 * WIDTH;
    localparam int CW       = $clog2(ROW_LEN);
    localparam int RW       = $clog2(COL_LEN);
    localparam int LB_DEPTH = ROW_LEN / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int LAST_COL = (ROW_LEN / 2) * 2 - 1;
    localparam int LAST_ROW = (COL_LEN / 2) * 2 - 1;

    logic        [CW-1:0]    r_col_cnt;
    logic        [RW-1:0]    r_row_cnt;
    logic signed [DW-1:0]    r_h_max;
    logic signed [DW-1:0]    r_lbuf [0:LB_DEPTH-1];
    logic                    r_out_valid;
    logic        [DW-1:0]    r_data_out;
    logic                    r_frame_done;

    logic signed [DW-1:0]    w_v;
    logic        [LB_AW-1:0] w_lb_idx;
    logic signed [DW-1:0]    w_lb_rd;
    logic signed [DW-1:0]    w_max_hv;
    logic signed [DW-1:0]    w_max_all;
    logic                    w_col_use;
    logic                    w_row_use;
    logic                    w_col_wrap;
    logic                    w_row_wrap;
    logic                    w_last_win;

`ifdef RELU_EN
    assign w_v = data_in[DW-1] ? '0 : $signed(data_in);
`else
    assign w_v = $signed(data_in);
`endif

    assign w_lb_idx  = LB_AW'(r_col_cnt >> 1);
    assign w_lb_rd   = r_lbuf[w_lb_idx];
    assign w_max_hv  = (r_h_max > w_v) ? r_h_max : w_v;
    assign w_max_all = (w_lb_rd > w_max_hv) ? w_lb_rd : w_max_hv;

    // With an odd dimension the trailing column/row has no partner and is
    // consumed without touching the pooling state.
    assign w_col_use = !((ROW_LEN % 2 == 1) && (r_col_cnt == CW'(ROW_LEN - 1)));
    assign w_row_use = !((COL_LEN % 2 == 1) && (r_row_cnt == RW'(COL_LEN - 1)));

    assign w_col_wrap = (r_col_cnt == CW'(ROW_LEN - 1));
    assign w_row_wrap = (r_row_cnt == RW'(COL_LEN - 1));
    assign w_last_win = (r_row_cnt == RW'(LAST_ROW)) && (r_col_cnt == CW'(LAST_COL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_h_max      <= '0;
            r_out_valid  <= 1'b0;
            r_data_out   <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < LB_DEPTH; i++) begin
                r_lbuf[i] <= '0;
            end
        end else if (clear) begin
            // Line buffer is left alone: every entry is rewritten on the
            // even row before the odd row reads it back.
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_h_max      <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (in_valid) begin
                if (w_col_use && w_row_use) begin
                    if (!r_col_cnt[0]) begin
                        r_h_max <= w_v;
                    end else if (!r_row_cnt[0]) begin
                        r_lbuf[w_lb_idx] <= w_max_hv;
                    end else begin
                        r_data_out   <= w_max_all;
                        r_out_valid  <= 1'b1;
                        r_frame_done <= w_last_win;
                    end
                end

                if (w_col_wrap) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_wrap ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_relu_pool.sv
module tb_conv_relu_pool;

    localparam int W  = 9;
    localparam int DW = 2 * W;

    typedef logic [DW-1:0] dq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic          ov_a, fd_a, ov_b, fd_b;
    logic [DW-1:0] do_a, do_b;

    int n_pass = 0;
    int n_total = 0;

    conv_relu_pool #(.WIDTH(W), .ROW_LEN(4), .COL_LEN(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .data_in(data_in), .out_valid(ov_a), .data_out(do_a), .frame_done(fd_a)
    );

    conv_relu_pool #(.WIDTH(W), .ROW_LEN(5), .COL_LEN(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .data_in(data_in), .out_valid(ov_b), .data_out(do_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    // Reference model: stores the whole frame per geometry (4x4 and 5x5) and
    // pools each 2x2 window once its bottom-right pixel arrives.
    logic signed [DW-1:0] pix [2][5][5];
    int                   mx [2];
    int                   my [2];
    logic                 m_ov [2];
    logic                 m_fd [2];
    logic        [DW-1:0] m_do [2];

    dq_t qa, qb;
    int  fda, fdb;

    function automatic logic signed [DW-1:0] pixval(input logic [DW-1:0] d);
`ifdef RELU_EN
        return d[DW-1] ? '0 : $signed(d);
`else
        return $signed(d);
`endif
    endfunction

    function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic signed [DW-1:0] c,
                                                  input logic signed [DW-1:0] d);
        logic signed [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            mx[g] = 0; my[g] = 0; m_ov[g] = 1'b0; m_fd[g] = 1'b0; m_do[g] = '0;
        end
    endtask

    task automatic model_step(input logic v, input logic c, input logic [DW-1:0] d);
        for (int g = 0; g < 2; g++) begin
            int len;
            len = (g == 0) ? 4 : 5;
            m_ov[g] = 1'b0;
            m_fd[g] = 1'b0;
            if (c) begin
                mx[g] = 0; my[g] = 0;
            end else if (v) begin
                pix[g][my[g]][mx[g]] = pixval(d);
                if ((my[g] % 2 == 1) && (mx[g] % 2 == 1)) begin
                    m_ov[g] = 1'b1;
                    m_do[g] = max4(pix[g][my[g]-1][mx[g]-1], pix[g][my[g]-1][mx[g]],
                                   pix[g][my[g]][mx[g]-1], pix[g][my[g]][mx[g]]);
                    m_fd[g] = (my[g] == (len / 2) * 2 - 1) && (mx[g] == (len / 2) * 2 - 1);
                end
                mx[g]++;
                if (mx[g] == len) begin
                    mx[g] = 0;
                    my[g] = (my[g] == len - 1) ? 0 : my[g] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outs();
        chk("a_out_valid",  DW'(ov_a), DW'(m_ov[0]));
        chk("a_frame_done", DW'(fd_a), DW'(m_fd[0]));
        chk("a_data_out",   do_a,      m_do[0]);
        chk("b_out_valid",  DW'(ov_b), DW'(m_ov[1]));
        chk("b_frame_done", DW'(fd_b), DW'(m_fd[1]));
        chk("b_data_out",   do_b,      m_do[1]);
    endtask

    task automatic step(input logic v, input logic c, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v; clear = c; data_in = d;
        @(posedge clk);
        #1;
        model_step(v, c, d);
        check_outs();
        if (ov_a) qa.push_back(do_a);
        if (ov_b) qb.push_back(do_b);
        if (fd_a) fda++;
        if (fd_b) fdb++;
    endtask

    task automatic clr_q();
        qa.delete(); qb.delete(); fda = 0; fdb = 0;
    endtask

    // Reset is asserted away from any clock edge to exercise the async path.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        clr_q();
    endtask

    task automatic ramp(input int n, input int base, input int sgn);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, DW'(base + sgn * k));
    endtask

    task automatic chk_list(input string tag, input dq_t got, input dq_t exp);
        chk({tag, "_count"}, DW'(got.size()), DW'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    initial begin
        dq_t e;
        int k;
        int budget;

        // Ramp 0..15 on the 4x4 instance.
        do_reset();
        ramp(16, 0, 1);
        e = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        chk_list("ramp4", qa, e);
        chk("ramp4_fd_count", DW'(fda), DW'(1));

        // Negative window in the corner, -1 everywhere else.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] d;
            case (i)
                0:       d = DW'(-5);
                1:       d = DW'(-3);
                4:       d = DW'(-9);
                5:       d = DW'(-4);
                default: d = DW'(-1);
            endcase
            step(1'b1, 1'b0, d);
        end
`ifdef RELU_EN
        e = '{DW'(0), DW'(0), DW'(0), DW'(0)};
`else
        e = '{DW'(-3), DW'(-1), DW'(-1), DW'(-1)};
`endif
        chk_list("neg", qa, e);

        // Ramp with idle gaps.
        do_reset();
        k = 0;
        budget = 0;
        while (k < 16 && budget < 400) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, 1'b0, DW'(k));
                k++;
            end else begin
                step(1'b0, 1'b0, DW'($urandom));
            end
            budget++;
        end
        chk("gap_budget", DW'(k), DW'(16));
        e = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        chk_list("gaps", qa, e);

        // Two 5x5 ramp frames on the odd-geometry instance.
        do_reset();
        ramp(25, 0, 1);
        ramp(25, 0, 1);
        e = '{DW'(6), DW'(8), DW'(16), DW'(18), DW'(6), DW'(8), DW'(16), DW'(18)};
        chk_list("ramp5", qb, e);
        chk("ramp5_fd_count", DW'(fdb), DW'(2));

        // Async reset mid-frame, then a fresh frame.
        do_reset();
        ramp(6, 0, 1);
        do_reset();
        ramp(16, 0, 1);
        e = '{DW'(5), DW'(7), DW'(13), DW'(15)};
        chk_list("after_rst", qa, e);

        // Clear mid-frame, with a sample on the same cycle that must be dropped.
        do_reset();
        ramp(6, 0, 1);
        step(1'b1, 1'b1, DW'(999));
        clr_q();
        ramp(16, 0, 1);
        chk_list("after_clear", qa, e);
        chk("after_clear_fd_count", DW'(fda), DW'(1));

        // Back-to-back frames: ramp up, then 100-k.
        do_reset();
        ramp(16, 0, 1);
        ramp(16, 100, -1);
        e = '{DW'(5), DW'(7), DW'(13), DW'(15), DW'(100), DW'(98), DW'(92), DW'(90)};
        chk_list("b2b", qa, e);
        chk("b2b_fd_count", DW'(fda), DW'(2));

        // Random data, random gaps and occasional clears against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
